fp_add_control: RTL and testbench

//  Control unit (FSM) for the single-precision FP adder Datapath. Accepts a start pulse and sequences the datapath:

---
 rtl/fp_add_pkg.sv | 31 +++
 rtl/fp_align_sat.sv | 23 ++
 rtl/fp_add_control.sv | 225 ++++++++++++++++++++++
 tb/tb_fp_add_control.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared definitions for the FP adder control slice.
//   - FSM state encoding (4-bit)
//   - big-ULA opcodes
//   - datapath widths and exponent / alignment limits
package fp_add_pkg;

  localparam int unsigned MANT_W  = 26;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned SHIFT_W = 5;

  localparam logic [7:0] EXP_MAX   = 8'd255;
  // Shifting right by the full mantissa width already clears it.
  localparam logic [4:0] ALIGN_SAT = 5'd26;

  localparam logic [3:0] ULA_ADD = 4'h0;
  localparam logic [3:0] ULA_SUB = 4'h1;

  typedef enum logic [3:0] {
    StIdle,
    StAlign,
    StAdd,
    StNormChk,
    StShiftR,
    StShiftL,
    StRound,
    StRoundChk,
    StZero,
    StDone
  } state_e;

endpackage

// File: rtl/fp_align_sat.sv
// Saturating conversion of the exponent difference into an alignment shift amount.
// Ports:
//   i_diff   in   DIFF_W   |expA - expB|
//   o_shift  out  SHIFT_W  min(i_diff, SAT_VAL)
module fp_align_sat
  import fp_add_pkg::*;
#(
  parameter int unsigned        DIFF_W  = 8,
  parameter int unsigned        SHIFT_W = 5,
  parameter logic [SHIFT_W-1:0] SAT_VAL = SHIFT_W'(ALIGN_SAT)
) (
  input  logic [DIFF_W-1:0]  i_diff,
  output logic [SHIFT_W-1:0] o_shift
);

  always_comb begin
    o_shift = SAT_VAL;
    if (i_diff < DIFF_W'(SAT_VAL)) begin
      o_shift = i_diff[SHIFT_W-1:0];
    end
  end

endmodule

// File: rtl/fp_add_control.sv
// Control FSM for the single-precision FP adder datapath. On a start pulse it
// sequences exponent compare/alignment, mantissa add/sub, the normalisation
// loop, rounding (with one renormalisation) and the final output load.
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_start                         request one add (sampled only in idle)
//   i_sign_a, i_sign_b              operand signs
//   i_exp_a_lt_b, i_exp_diff        small-ULA compare result and |expA-expB|
//   i_mant_carry/hidden/zero        mantissa register status
//   i_round_carry                   rounding overflowed the mantissa
//   i_exp_result                    current exponent register value
//   o_decisor_* / o_subtrador_*     datapath mux/direction selects
//   o_exp_bypass                    load exponent unchanged
//   o_align_shift, o_norm_shift     shift amounts
//   o_ula_op                        big-ULA opcode
//   o_load_exp/mant/out             register enables
//   o_sign_result                   result sign
//   o_busy, o_done                  status; done is a one-cycle pulse
//   o_overflow, o_underflow         sticky until the next accepted start
module fp_add_control
  import fp_add_pkg::*;
#(
  parameter int unsigned MANT_W  = fp_add_pkg::MANT_W,
  parameter int unsigned EXP_W   = fp_add_pkg::EXP_W,
  parameter int unsigned SHIFT_W = fp_add_pkg::SHIFT_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_sign_a,
  input  logic               i_sign_b,
  input  logic               i_exp_a_lt_b,
  input  logic [EXP_W-1:0]   i_exp_diff,
  input  logic               i_mant_carry,
  input  logic               i_mant_hidden,
  input  logic               i_mant_zero,
  input  logic               i_round_carry,
  input  logic [EXP_W-1:0]   i_exp_result,
  output logic               o_decisor_mux_expoentes,
  output logic               o_decisor_mux_expoente_escolhido,
  output logic               o_decisor_mux_escolhe_shift_right,
  output logic               o_decisor_mux_entrada_dois_ula,
  output logic               o_decisor_mux_saida_big_ula,
  output logic               o_decisor_shift_right_left,
  output logic               o_subtrador_somador_subtrador,
  output logic               o_exp_bypass,
  output logic [SHIFT_W-1:0] o_align_shift,
  output logic [SHIFT_W-1:0] o_norm_shift,
  output logic [3:0]         o_ula_op,
  output logic               o_load_exp,
  output logic               o_load_mant,
  output logic               o_load_out,
  output logic               o_sign_result,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic               o_underflow
);

  state_e             r_state;
  state_e             w_state_next;
  logic               r_lt;
  logic               r_sa;
  logic               r_sb;
  logic [EXP_W-1:0]   r_diff;
  logic               r_round_done;
  logic               r_overflow;
  logic               r_underflow;
  logic [SHIFT_W-1:0] w_align_shift;
  logic               w_exp_at_max;
  logic               w_exp_at_min;
  logic               w_accept;

  // One more increment would produce the all-ones (inf/NaN) exponent.
  assign w_exp_at_max = (i_exp_result == EXP_W'(EXP_MAX - 8'd1));
  // Decrementing below 1 would leave the normal range.
  assign w_exp_at_min = (i_exp_result <= EXP_W'(1));
  assign w_accept     = (r_state == StIdle) && i_start;

  fp_align_sat #(
    .DIFF_W  (EXP_W),
    .SHIFT_W (SHIFT_W),
    .SAT_VAL (SHIFT_W'(MANT_W))
  ) u_align_sat (
    .i_diff  (r_diff),
    .o_shift (w_align_shift)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand latches and sticky flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lt         <= 1'b0;
      r_sa         <= 1'b0;
      r_sb         <= 1'b0;
      r_diff       <= '0;
      r_round_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (w_accept) begin
      r_lt         <= i_exp_a_lt_b;
      r_sa         <= i_sign_a;
      r_sb         <= i_sign_b;
      r_diff       <= i_exp_diff;
      r_round_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (r_state == StRound) begin
        r_round_done <= 1'b1;
      end
      if ((r_state == StShiftR) && w_exp_at_max) begin
        r_overflow <= 1'b1;
      end
      if ((r_state == StShiftL) && w_exp_at_min) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (i_start) w_state_next = StAlign;
      StAlign:    w_state_next = StAdd;
      StAdd:      w_state_next = StNormChk;
      StNormChk: begin
        if (i_mant_zero)        w_state_next = StZero;
        else if (i_mant_carry)  w_state_next = StShiftR;
        else if (!i_mant_hidden) w_state_next = StShiftL;
        else if (r_round_done)  w_state_next = StDone;
        else                    w_state_next = StRound;
      end
      StShiftR:   w_state_next = w_exp_at_max ? StDone : StNormChk;
      StShiftL:   w_state_next = w_exp_at_min ? StDone : StNormChk;
      StRound:    w_state_next = StRoundChk;
      // A rounding carry gets one renormalisation; round_done stops a second round.
      StRoundChk: w_state_next = i_round_carry ? StShiftR : StDone;
      StZero:     w_state_next = StDone;
      StDone:     w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // Moore output decode
  always_comb begin
    o_decisor_mux_expoentes           = 1'b0;
    o_decisor_mux_expoente_escolhido  = 1'b0;
    o_decisor_mux_escolhe_shift_right = 1'b0;
    o_decisor_mux_entrada_dois_ula    = 1'b0;
    o_decisor_mux_saida_big_ula       = 1'b0;
    o_decisor_shift_right_left        = 1'b0;
    o_subtrador_somador_subtrador     = 1'b0;
    o_exp_bypass                      = 1'b0;
    o_align_shift                     = '0;
    o_norm_shift                      = '0;
    o_ula_op                          = ULA_ADD;
    o_load_exp                        = 1'b0;
    o_load_mant                       = 1'b0;
    o_load_out                        = 1'b0;
    o_sign_result                     = 1'b0;
    o_done                            = 1'b0;
    unique case (r_state)
      StAlign: begin
        // The smaller-exponent operand is the one aligned.
        o_decisor_mux_expoentes           = r_lt;
        o_decisor_mux_escolhe_shift_right = ~r_lt;
        o_decisor_mux_entrada_dois_ula    = ~r_lt;
        o_align_shift                     = w_align_shift;
        o_ula_op                          = (r_sa ^ r_sb) ? ULA_SUB : ULA_ADD;
      end
      StAdd: begin
        o_load_mant   = 1'b1;
        o_load_exp    = 1'b1;
        o_exp_bypass  = 1'b1;
        o_sign_result = r_lt ? r_sb : r_sa;
      end
      StShiftR: begin
        o_norm_shift                     = SHIFT_W'(1);
        o_decisor_mux_saida_big_ula      = 1'b1;
        o_decisor_mux_expoente_escolhido = 1'b1;
        o_load_mant                      = 1'b1;
        o_load_exp                       = 1'b1;
      end
      StShiftL: begin
        if (!w_exp_at_min) begin
          o_norm_shift                     = SHIFT_W'(1);
          o_decisor_shift_right_left       = 1'b1;
          o_decisor_mux_saida_big_ula      = 1'b1;
          o_decisor_mux_expoente_escolhido = 1'b1;
          o_subtrador_somador_subtrador    = 1'b1;
          o_load_mant                      = 1'b1;
          o_load_exp                       = 1'b1;
        end
      end
      StRound: begin
        o_load_mant = 1'b1;
      end
      StZero: begin
        o_exp_bypass                     = 1'b1;
        o_decisor_mux_expoente_escolhido = 1'b1;
        o_load_exp                       = 1'b1;
      end
      StDone: begin
        o_load_out = 1'b1;
        o_done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_busy      = (r_state != StIdle);
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_fp_add_control.sv
// Directed bench for fp_add_control: walks state sequences and compares the full
// output vector each cycle against hand-built expectations.
module tb_fp_add_control;

  typedef struct packed {
    logic       mux_exp;
    logic       escolhido;
    logic       sh_sel;
    logic       ula_b;
    logic       saida;
    logic       lr;
    logic       subtr;
    logic       bypass;
    logic [4:0] align;
    logic [4:0] norm;
    logic [3:0] op;
    logic       ld_exp;
    logic       ld_mant;
    logic       ld_out;
    logic       sign;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       unf;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset, start, sign_a, sign_b, lt, carry, hidden, mzero, rcarry;
  logic [7:0] diff, exp_res;

  logic       o_mux_exp, o_escolhido, o_sh_sel, o_ula_b, o_saida, o_lr, o_subtr, o_bypass;
  logic [4:0] o_align, o_norm;
  logic [3:0] o_op;
  logic       o_ld_exp, o_ld_mant, o_ld_out, o_sign, o_busy, o_done, o_ovf, o_unf;
  outs_t      obs;

  int n_total = 0;
  int n_pass  = 0;
  logic x_ovf = 1'b0;
  logic x_unf = 1'b0;

  always #5 clk = ~clk;

  fp_add_control u_dut (
    .i_clk                             (clk),
    .i_reset                           (reset),
    .i_start                           (start),
    .i_sign_a                          (sign_a),
    .i_sign_b                          (sign_b),
    .i_exp_a_lt_b                      (lt),
    .i_exp_diff                        (diff),
    .i_mant_carry                      (carry),
    .i_mant_hidden                     (hidden),
    .i_mant_zero                       (mzero),
    .i_round_carry                     (rcarry),
    .i_exp_result                      (exp_res),
    .o_decisor_mux_expoentes           (o_mux_exp),
    .o_decisor_mux_expoente_escolhido  (o_escolhido),
    .o_decisor_mux_escolhe_shift_right (o_sh_sel),
    .o_decisor_mux_entrada_dois_ula    (o_ula_b),
    .o_decisor_mux_saida_big_ula       (o_saida),
    .o_decisor_shift_right_left        (o_lr),
    .o_subtrador_somador_subtrador     (o_subtr),
    .o_exp_bypass                      (o_bypass),
    .o_align_shift                     (o_align),
    .o_norm_shift                      (o_norm),
    .o_ula_op                          (o_op),
    .o_load_exp                        (o_ld_exp),
    .o_load_mant                       (o_ld_mant),
    .o_load_out                        (o_ld_out),
    .o_sign_result                     (o_sign),
    .o_busy                            (o_busy),
    .o_done                            (o_done),
    .o_overflow                        (o_ovf),
    .o_underflow                       (o_unf)
  );

  assign obs = {o_mux_exp, o_escolhido, o_sh_sel, o_ula_b, o_saida, o_lr, o_subtr, o_bypass,
                o_align, o_norm, o_op, o_ld_exp, o_ld_mant, o_ld_out, o_sign, o_busy, o_done,
                o_ovf, o_unf};

  // Expected output vectors per state
  function automatic outs_t e_idle();
    outs_t e;
    e = '0;
    return e;
  endfunction

  function automatic outs_t e_busy();
    outs_t e;
    e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_align(input logic l, input logic [4:0] a, input logic [3:0] op);
    outs_t e;
    e = e_busy();
    e.mux_exp = l;
    e.sh_sel  = ~l;
    e.ula_b   = ~l;
    e.align   = a;
    e.op      = op;
    return e;
  endfunction

  function automatic outs_t e_add(input logic s);
    outs_t e;
    e = e_busy();
    e.ld_mant = 1'b1;
    e.ld_exp  = 1'b1;
    e.bypass  = 1'b1;
    e.sign    = s;
    return e;
  endfunction

  function automatic outs_t e_shr();
    outs_t e;
    e = e_busy();
    e.norm      = 5'd1;
    e.saida     = 1'b1;
    e.escolhido = 1'b1;
    e.ld_mant   = 1'b1;
    e.ld_exp    = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_shl();
    outs_t e;
    e = e_shr();
    e.lr    = 1'b1;
    e.subtr = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_round();
    outs_t e;
    e = e_busy();
    e.ld_mant = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_zero();
    outs_t e;
    e = e_busy();
    e.bypass    = 1'b1;
    e.escolhido = 1'b1;
    e.ld_exp    = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_done();
    outs_t e;
    e = e_busy();
    e.ld_out = 1'b1;
    e.done   = 1'b1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input outs_t e);
    logic [29:0] got, want;
    e.ovf = x_ovf;
    e.unf = x_unf;
    got   = obs;
    want  = e;
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, want);
  endtask

  // Pulse start with the given operand info; leaves the DUT in ALIGN.
  task automatic go(input logic l, input logic [7:0] d, input logic a, input logic b);
    start  = 1'b1;
    lt     = l;
    diff   = d;
    sign_a = a;
    sign_b = b;
    tick();
    start  = 1'b0;
    x_ovf  = 1'b0;
    x_unf  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sign_a = 1'b0; sign_b = 1'b0; lt = 1'b0;
    carry = 1'b0; hidden = 1'b1; mzero = 1'b0; rcarry = 1'b0;
    diff = 8'd0; exp_res = 8'd127;
    tick(); tick();
    chk("reset_held", e_idle());
    reset = 1'b0;
    tick();
    chk("idle_after_reset", e_idle());

    // 1.0 + 1.0: carry out -> one right shift, done at cycle 8
    go(1'b0, 8'd0, 1'b0, 1'b0);
    chk("a_align", e_align(1'b0, 5'd0, 4'h0));
    carry = 1'b1;
    tick(); chk("a_add", e_add(1'b0));
    tick(); chk("a_norm1", e_busy());
    tick(); chk("a_shr", e_shr());
    carry = 1'b0; exp_res = 8'd128;
    tick(); chk("a_norm2", e_busy());
    tick(); chk("a_round", e_round());
    tick(); chk("a_rchk", e_busy());
    tick(); chk("a_done_c8", e_done());
    tick(); chk("a_idle", e_idle());

    // 1.0 + (-1.0): subtract, zero result, done at cycle 5
    exp_res = 8'd127;
    go(1'b0, 8'd0, 1'b0, 1'b1);
    chk("b_align_sub", e_align(1'b0, 5'd0, 4'h1));
    mzero = 1'b1;
    tick(); chk("b_add", e_add(1'b0));
    tick(); chk("b_norm", e_busy());
    tick(); chk("b_zero", e_zero());
    tick(); chk("b_done_c5", e_done());
    mzero = 1'b0;
    tick(); chk("b_idle", e_idle());

    // Large diff with B larger: saturated alignment, sign from B
    go(1'b1, 8'd40, 1'b0, 1'b1);
    chk("c_align_sat40", e_align(1'b1, 5'd26, 4'h1));
    tick(); chk("c_add_sign_b", e_add(1'b1));
    tick(); chk("c_norm", e_busy());
    tick(); chk("c_round", e_round());
    tick(); chk("c_rchk", e_busy());
    tick(); chk("c_done_c6", e_done());
    tick(); chk("c_idle", e_idle());

    // Overflow: exponent 254 plus carry; diff=25 just below saturation
    go(1'b0, 8'd25, 1'b1, 1'b1);
    chk("d_align_25", e_align(1'b0, 5'd25, 4'h0));
    carry = 1'b1; exp_res = 8'd254;
    tick(); chk("d_add_sign_a", e_add(1'b1));
    tick(); chk("d_norm", e_busy());
    tick(); chk("d_shr", e_shr());
    x_ovf = 1'b1;
    tick(); chk("d_done_ovf", e_done());
    carry = 1'b0; exp_res = 8'd127;
    tick(); chk("d_idle_ovf_sticky", e_idle());
    tick(); chk("d_idle_ovf_sticky2", e_idle());

    // Rounding carry: single renormalisation, no second round; diff=26 boundary
    go(1'b0, 8'd26, 1'b0, 1'b0);
    chk("e_align_ovf_clr_26", e_align(1'b0, 5'd26, 4'h0));
    tick(); chk("e_add", e_add(1'b0));
    tick(); chk("e_norm1", e_busy());
    tick(); chk("e_round", e_round());
    rcarry = 1'b1;
    tick(); chk("e_rchk", e_busy());
    tick(); chk("e_shr", e_shr());
    rcarry = 1'b0;
    tick(); chk("e_norm2", e_busy());
    tick(); chk("e_done_once", e_done());
    tick(); chk("e_idle", e_idle());
    tick(); chk("e_no_second_done", e_idle());

    // Start held high while busy, operand inputs changed mid-op
    go(1'b0, 8'd3, 1'b0, 1'b1);
    start = 1'b1;
    chk("f_align", e_align(1'b0, 5'd3, 4'h1));
    lt = 1'b1; diff = 8'd9; sign_a = 1'b1;
    tick(); chk("f_add_latched", e_add(1'b0));
    tick(); chk("f_norm", e_busy());
    tick(); chk("f_round", e_round());
    tick(); chk("f_rchk", e_busy());
    tick(); chk("f_done", e_done());
    start = 1'b0;
    tick(); chk("f_idle", e_idle());

    // Underflow: hidden bit clear with exponent at 1
    hidden = 1'b0; exp_res = 8'd1;
    go(1'b0, 8'd0, 1'b0, 1'b0);
    chk("g_align", e_align(1'b0, 5'd0, 4'h0));
    tick(); chk("g_add", e_add(1'b0));
    tick(); chk("g_norm", e_busy());
    tick(); chk("g_shl_noshift", e_busy());
    x_unf = 1'b1;
    tick(); chk("g_done_unf", e_done());
    tick(); chk("g_idle_unf", e_idle());

    // Normal left shifts, then reset while in SHIFT_L
    exp_res = 8'd5;
    go(1'b0, 8'd0, 1'b0, 1'b0);
    chk("h_align_unf_clr", e_align(1'b0, 5'd0, 4'h0));
    tick(); chk("h_add", e_add(1'b0));
    tick(); chk("h_norm1", e_busy());
    tick(); chk("h_shl1", e_shl());
    exp_res = 8'd4;
    tick(); chk("h_norm2", e_busy());
    tick(); chk("h_shl2", e_shl());
    reset = 1'b1; start = 1'b1;
    tick(); chk("h_reset_idle", e_idle());
    reset = 1'b0; start = 1'b0; hidden = 1'b1;
    tick(); chk("h_idle_no_done", e_idle());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
